dcache_port_arb: RTL and testbench

// - Shares the single Dcache request port between LQ load issues and SQ-head retired-store writebacks.
// - Sits between the LSQ and the Dcache/MSHR, replacing direct LSQ drive of the lsq2Dcache_* request signals.
// - Holds one registered request until the Dcache accepts it; loads have priority, stores win when forced.
// - Squashes a held or incoming load on branch mispredict.

---
 rtl/sys_defs.sv | 12 +
 rtl/arb_starve_ctr.sv | 36 +++
 rtl/dcache_port_arb.sv | 109 ++++++++++
 tb/tb_dcache_port_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared LSQ/Dcache definitions used by the Dcache port arbiter.
package sys_defs;

  localparam int BR_MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_PEND = 2'd1,
    ST_PEND = 2'd2
  } dc_arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of load grants that passed over a waiting store.
module arb_starve_ctr #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/dcache_port_arb.sv
// rtl/dcache_port_arb.sv - shares the single Dcache request port between LQ loads and SQ-head stores.
module dcache_port_arb
  import sys_defs::*;
#(
  parameter int ST_STARVE_MAX = 4,
  parameter int CNT_W         = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_req_vld_i,
  input  logic [63:0]          ld_addr_i,
  input  logic [BR_MASK_W-1:0] ld_br_mask_i,
  output logic                 ld_req_rdy_o,
  input  logic                 st_req_vld_i,
  input  logic [63:0]          st_addr_i,
  input  logic [63:0]          st_data_i,
  output logic                 st_req_rdy_o,
  input  logic                 sq_full_i,
  input  logic                 rob_br_recovery_i,
  input  logic                 rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
  input  logic                 Dcache_req_ack_i,
  input  logic                 Dcache_mshr_stall_i,
  output logic                 lsq2Dcache_ld_en_o,
  output logic [63:0]          lsq2Dcache_ld_addr_o,
  output logic                 lsq2Dcache_st_en_o,
  output logic [63:0]          lsq2Dcache_st_addr_o,
  output logic [63:0]          lsq2Dcache_st_data_o
);

  dc_arb_state_t        state_q, state_d;
  logic [63:0]          ld_addr_q, ld_addr_d;
  logic [BR_MASK_W-1:0] ld_mask_q, ld_mask_d;
  logic [63:0]          st_addr_q, st_addr_d;
  logic [63:0]          st_data_q, st_data_d;

  logic starve_at_max;
  logic ld_squash, accept, slot_free, ld_ok, force_st, ld_grant, st_grant;
  logic [BR_MASK_W-1:0] clr_mask;

  arb_starve_ctr #(
    .MAX (ST_STARVE_MAX),
    .W   (CNT_W)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (ld_grant & st_req_vld_i),
    .clr_i    (st_grant),
    .at_max_o (starve_at_max)
  );

  always_comb begin
    ld_squash = (state_q == LD_PEND) & rob_br_recovery_i & (|(ld_mask_q & rob_br_tag_fix_i));
    // A squashed load is never treated as accepted, even with ack high.
    accept    = (state_q != IDLE) & Dcache_req_ack_i & ~Dcache_mshr_stall_i & ~ld_squash;
    slot_free = (state_q == IDLE) | accept | ld_squash;
    ld_ok     = ld_req_vld_i & ~(rob_br_recovery_i & (|(ld_br_mask_i & rob_br_tag_fix_i)));
    force_st  = st_req_vld_i & (sq_full_i | starve_at_max | ~ld_ok);
    // Grants are suppressed while reset is held so the LSQ never advances during reset.
    st_grant  = rst_n & slot_free & force_st;
    ld_grant  = rst_n & slot_free & ~force_st & ld_ok;
    clr_mask  = rob_br_pred_correct_i ? rob_br_tag_fix_i : '0;

    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    ld_mask_d = ld_mask_q & ~clr_mask;
    st_addr_d = st_addr_q;
    st_data_d = st_data_q;

    if (slot_free) begin
      if (st_grant) begin
        state_d   = ST_PEND;
        st_addr_d = st_addr_i;
        st_data_d = st_data_i;
      end else if (ld_grant) begin
        state_d   = LD_PEND;
        ld_addr_d = ld_addr_i;
        ld_mask_d = ld_br_mask_i & ~clr_mask;
      end else begin
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ld_addr_q <= '0;
      ld_mask_q <= '0;
      st_addr_q <= '0;
      st_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      ld_mask_q <= ld_mask_d;
      st_addr_q <= st_addr_d;
      st_data_q <= st_data_d;
    end
  end

  assign ld_req_rdy_o         = ld_grant;
  assign st_req_rdy_o         = st_grant;
  assign lsq2Dcache_ld_en_o   = (state_q == LD_PEND);
  assign lsq2Dcache_st_en_o   = (state_q == ST_PEND);
  assign lsq2Dcache_ld_addr_o = ld_addr_q;
  assign lsq2Dcache_st_addr_o = st_addr_q;
  assign lsq2Dcache_st_data_o = st_data_q;

endmodule

// File: tb/tb_dcache_port_arb.sv
// tb/tb_dcache_port_arb.sv - directed scoreboard bench for the Dcache port arbiter.
module tb_dcache_port_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_req_vld, st_req_vld, sq_full;
  logic [63:0] ld_addr, st_addr, st_data;
  logic [3:0]  ld_br_mask, tag_fix;
  logic        recovery, pred_correct, ack, stall;
  logic        ld_rdy, st_rdy, ld_en, st_en;
  logic [63:0] ld_addr_o, st_addr_o, st_data_o;

  always #5 clk = ~clk;

  dcache_port_arb dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ld_req_vld_i          (ld_req_vld),
    .ld_addr_i             (ld_addr),
    .ld_br_mask_i          (ld_br_mask),
    .ld_req_rdy_o          (ld_rdy),
    .st_req_vld_i          (st_req_vld),
    .st_addr_i             (st_addr),
    .st_data_i             (st_data),
    .st_req_rdy_o          (st_rdy),
    .sq_full_i             (sq_full),
    .rob_br_recovery_i     (recovery),
    .rob_br_pred_correct_i (pred_correct),
    .rob_br_tag_fix_i      (tag_fix),
    .Dcache_req_ack_i      (ack),
    .Dcache_mshr_stall_i   (stall),
    .lsq2Dcache_ld_en_o    (ld_en),
    .lsq2Dcache_ld_addr_o  (ld_addr_o),
    .lsq2Dcache_st_en_o    (st_en),
    .lsq2Dcache_st_addr_o  (st_addr_o),
    .lsq2Dcache_st_data_o  (st_data_o)
  );

  typedef struct {
    logic        is_st;
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic sq_flag = 1'b0;
  logic ld_rdy_s, st_rdy_s, ld_en_s, st_en_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Samples mid-cycle; a presented, acked, unstalled, unsquashed request is scored.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    ld_rdy_s = ld_rdy;
    st_rdy_s = st_rdy;
    ld_en_s  = ld_en;
    st_en_s  = st_en;
    if ((ld_en_s || st_en_s) && ack && !stall && !sq_flag) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed accept expected none");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk1("sb_kind", st_en_s, e.is_st);
        chk("sb_addr", st_en_s ? st_addr_o : ld_addr_o, e.addr);
        if (e.is_st) chk("sb_data", st_data_o, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_st, input logic [63:0] a, input logic [63:0] d);
    exp_t e;
    e.is_st = is_st;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int lcount;
    int scount;
    logic is_st;
    exp_t dropped;

    rst_n = 1'b0;
    ld_req_vld = 1'b1; st_req_vld = 1'b1; sq_full = 1'b0;
    ld_addr = 64'h40; st_addr = 64'h80; st_data = 64'h1;
    ld_br_mask = '0; tag_fix = '0; recovery = 1'b0; pred_correct = 1'b0;
    ack = 1'b1; stall = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk1("rst_ld_en", ld_en, 1'b0);
    chk1("rst_st_en", st_en, 1'b0);
    chk("rst_ld_addr", ld_addr_o, 64'h0);
    chk("rst_st_addr", st_addr_o, 64'h0);
    chk("rst_st_data", st_data_o, 64'h0);
    chk1("rst_ld_rdy", ld_rdy, 1'b0);
    chk1("rst_st_rdy", st_rdy, 1'b0);
    ld_req_vld = 1'b0; st_req_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single load, ack every cycle.
    ld_req_vld = 1'b1; ld_addr = 64'h100;
    cyc();
    chk1("ld1_rdy", ld_rdy_s, 1'b1);
    chk1("ld1_st_rdy", st_rdy_s, 1'b0);
    push(1'b0, 64'h100, 64'h0);
    ld_req_vld = 1'b0;
    cyc();
    chk1("ld1_en", ld_en_s, 1'b1);
    chk1("ld1_st_en", st_en_s, 1'b0);
    cyc();
    chk1("ld1_idle", ld_en_s, 1'b0);

    // Loads and a store both valid every cycle: four loads then a forced store.
    lcount = 0;
    scount = 0;
    for (int i = 0; i < 10; i++) begin
      is_st = ((i % 5) == 4);
      ld_req_vld = 1'b1; ld_addr = 64'h200 + 64'(lcount * 8);
      st_req_vld = 1'b1; st_addr = 64'h3000 + 64'(scount * 16); st_data = 64'hD000 + 64'(scount);
      cyc();
      chk1("starve_ld_rdy", ld_rdy_s, !is_st);
      chk1("starve_st_rdy", st_rdy_s, is_st);
      if (is_st) begin
        push(1'b1, st_addr, st_data);
        scount++;
      end else begin
        push(1'b0, ld_addr, 64'h0);
        lcount++;
      end
    end
    ld_req_vld = 1'b0; st_req_vld = 1'b0;
    cyc();

    // SQ full forces the store ahead of a ready load.
    ld_req_vld = 1'b1; ld_addr = 64'h500;
    st_req_vld = 1'b1; st_addr = 64'h600; st_data = 64'hCAFE;
    sq_full = 1'b1;
    cyc();
    chk1("full_st_rdy", st_rdy_s, 1'b1);
    chk1("full_ld_rdy", ld_rdy_s, 1'b0);
    push(1'b1, 64'h600, 64'hCAFE);
    ld_req_vld = 1'b0; st_req_vld = 1'b0; sq_full = 1'b0;
    cyc();
    chk1("full_st_en", st_en_s, 1'b1);

    // Store held through three stalled cycles.
    st_req_vld = 1'b1; st_addr = 64'h700; st_data = 64'hBEEF;
    cyc();
    chk1("stall_grant", st_rdy_s, 1'b1);
    push(1'b1, 64'h700, 64'hBEEF);
    st_addr = 64'h780; st_data = 64'h1234;
    ld_req_vld = 1'b1; ld_addr = 64'h7C0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("stall_st_en", st_en_s, 1'b1);
      chk("stall_st_addr", st_addr_o, 64'h700);
      chk("stall_st_data", st_data_o, 64'hBEEF);
      chk1("stall_st_rdy", st_rdy_s, 1'b0);
      chk1("stall_ld_rdy", ld_rdy_s, 1'b0);
    end
    stall = 1'b0; st_req_vld = 1'b0; ld_req_vld = 1'b0;
    cyc();
    chk1("stall_accept_en", st_en_s, 1'b1);
    cyc();
    chk1("stall_after_en", st_en_s, 1'b0);

    // Held load squashed by a matching recovery despite ack.
    ld_req_vld = 1'b1; ld_addr = 64'h400; ld_br_mask = 4'b0010;
    cyc();
    chk1("sq_grant", ld_rdy_s, 1'b1);
    push(1'b0, 64'h400, 64'h0);
    recovery = 1'b1; tag_fix = 4'b0010; sq_flag = 1'b1;
    cyc();
    chk1("sq_held_en", ld_en_s, 1'b1);
    chk1("sq_incoming_rdy", ld_rdy_s, 1'b0);
    dropped = exp_q.pop_back();
    recovery = 1'b0; tag_fix = '0; sq_flag = 1'b0; ld_req_vld = 1'b0;
    cyc();
    chk1("sq_en_fall", ld_en_s, 1'b0);

    // Squash under stall drops the load and frees the slot for an unrelated load.
    ld_req_vld = 1'b1; ld_addr = 64'h440; ld_br_mask = 4'b0010;
    cyc();
    push(1'b0, 64'h440, 64'h0);
    stall = 1'b1; recovery = 1'b1; tag_fix = 4'b0010; sq_flag = 1'b1;
    ld_addr = 64'h480; ld_br_mask = 4'b0001;
    cyc();
    chk1("sq_stall_rdy", ld_rdy_s, 1'b1);
    dropped = exp_q.pop_back();
    push(1'b0, 64'h480, 64'h0);
    stall = 1'b0; recovery = 1'b0; tag_fix = '0; sq_flag = 1'b0; ld_req_vld = 1'b0;
    cyc();
    chk1("sq_stall_new_en", ld_en_s, 1'b1);
    chk("sq_stall_new_addr", ld_addr_o, 64'h480);

    // Non-matching recovery leaves the held load to be accepted.
    ld_req_vld = 1'b1; ld_addr = 64'h4C0; ld_br_mask = 4'b0010;
    cyc();
    push(1'b0, 64'h4C0, 64'h0);
    ld_req_vld = 1'b0; recovery = 1'b1; tag_fix = 4'b0100;
    cyc();
    chk1("nomatch_en", ld_en_s, 1'b1);
    recovery = 1'b0; tag_fix = '0;

    // A correctly predicted branch clears its bit while the mask is latched.
    ld_req_vld = 1'b1; ld_addr = 64'h800; ld_br_mask = 4'b0010;
    pred_correct = 1'b1; tag_fix = 4'b0010;
    cyc();
    chk1("pc_grant", ld_rdy_s, 1'b1);
    push(1'b0, 64'h800, 64'h0);
    pred_correct = 1'b0; ld_req_vld = 1'b0; recovery = 1'b1; tag_fix = 4'b0010;
    cyc();
    chk1("pc_en", ld_en_s, 1'b1);
    recovery = 1'b0; tag_fix = '0;
    cyc();
    chk1("pc_idle", ld_en_s, 1'b0);

    // Reset while a store is held drops it immediately.
    st_req_vld = 1'b1; st_addr = 64'h900; st_data = 64'h99;
    cyc();
    chk1("rst_mid_grant", st_rdy_s, 1'b1);
    chk1("rst_mid_en_before", st_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_en_async", st_en, 1'b0);
    exp_q.delete();
    @(negedge clk);
    chk1("rst_mid_no_grant", st_rdy, 1'b0);
    @(posedge clk);
    #1;
    chk1("rst_mid_en_hold", st_en, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("rst_release_rdy", st_rdy, 1'b1);
    push(1'b1, 64'h900, 64'h99);
    cyc();
    st_req_vld = 1'b0;
    cyc();
    chk1("rst_release_en", st_en_s, 1'b1);

    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
